mem_arbiter: RTL and testbench

- Shares one single-port synchronous memory between the instruction-fetch requester and the load/store requester of the multicycle core.
- Sits between Data_path and the unified memory.
- Sequences each access with a small FSM: grant, issue, latency wait, response.
- Generates byte enables, write-lane replication and read-lane extraction for byte/half/word accesses.
- Round-robin arbitration when both requesters collide.

---
 rtl/mem_arbiter.sv | 217 +++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port synchronous memory between instruction fetch and load/store.
// Each access walks IDLE -> ISSUE -> (WAIT) -> DONE; byte/half/word lanes are handled here.
module mem_arbiter #(
    parameter int WIDTH   = 32,
    parameter int ADDR_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [WIDTH-1:0]  i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [WIDTH-1:0]  d_wdata,
    input  logic              d_isByte,
    input  logic              d_isHalf,
    input  logic              d_isWord,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [WIDTH-1:0]  d_rdata,
    output logic              d_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WIDTH-1:0]  mem_wdata,
    output logic [3:0]        mem_be,
    input  logic [WIDTH-1:0]  mem_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t r_state;
    state_t w_state_next;

    logic              r_last_d;
    logic              r_win_d;
    logic              r_we;
    logic              r_err;
    logic              r_is_byte;
    logic              r_is_half;
    logic [1:0]        r_off;
    logic [ADDR_W-3:0] r_waddr;
    logic [3:0]        r_be;
    logic [WIDTH-1:0]  r_wdata;
    logic [WIDTH-1:0]  r_i_rdata;
    logic [WIDTH-1:0]  r_d_rdata;
    logic [2:0]        r_cnt;

    logic              w_any_req;
    logic              w_pick_d;
    logic              w_size_ok;
    logic              w_misaligned;
    logic              w_d_err;
    logic              w_cnt_last;
    logic [3:0]        w_d_be;
    logic [WIDTH-1:0]  w_d_wdata;
    logic [WIDTH-1:0]  w_shifted;
    logic [WIDTH-1:0]  w_extract;

    assign w_any_req    = i_req | d_req;
    // On a tie the requester that was not granted last wins.
    assign w_pick_d     = d_req & (~i_req | ~r_last_d);
    assign w_size_ok    = (d_isByte & ~d_isHalf & ~d_isWord) |
                          (~d_isByte & d_isHalf & ~d_isWord) |
                          (~d_isByte & ~d_isHalf & d_isWord);
    assign w_misaligned = (d_isHalf & d_addr[0]) | (d_isWord & (d_addr[1:0] != 2'b00));
    assign w_d_err      = ~w_size_ok | w_misaligned;
    assign w_cnt_last   = (r_cnt == 3'd1);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            assign w_d_be[gi] = d_isByte ? (d_addr[1:0] == LANE) :
                                d_isHalf ? (d_addr[1] == LANE[1]) : 1'b1;
            assign w_d_wdata[8*gi +: 8] = d_isByte ? d_wdata[7:0] :
                                          d_isHalf ? d_wdata[8*(gi%2) +: 8] :
                                                     d_wdata[8*gi +: 8];
        end
    endgenerate

    // Shifting by the byte offset right-justifies the addressed lane(s).
    assign w_shifted = mem_rdata >> {r_off, 3'b000};

    always_comb begin
        w_extract = mem_rdata;
        if (r_is_byte) begin
            w_extract = {{(WIDTH-8){1'b0}}, w_shifted[7:0]};
        end else if (r_is_half) begin
            w_extract = {{(WIDTH-16){1'b0}}, w_shifted[15:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        i_gnt        = 1'b0;
        d_gnt        = 1'b0;
        i_rvalid     = 1'b0;
        d_rvalid     = 1'b0;
        d_err        = 1'b0;
        mem_en       = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        mem_be       = 4'h0;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                i_gnt = ~r_win_d;
                d_gnt = r_win_d;
                if (!r_err) begin
                    mem_en    = 1'b1;
                    mem_we    = r_we;
                    mem_addr  = {r_waddr, 2'b00};
                    mem_wdata = r_wdata;
                    mem_be    = r_be;
                end
                w_state_next = (r_err | r_we) ? S_DONE : S_WAIT;
            end
            S_WAIT: begin
                if (w_cnt_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                i_rvalid     = ~r_win_d;
                d_rvalid     = r_win_d;
                d_err        = r_win_d & r_err;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_d  <= 1'b0;
            r_win_d   <= 1'b0;
            r_we      <= 1'b0;
            r_err     <= 1'b0;
            r_is_byte <= 1'b0;
            r_is_half <= 1'b0;
            r_off     <= 2'b00;
            r_waddr   <= '0;
            r_be      <= 4'h0;
            r_wdata   <= '0;
            r_i_rdata <= '0;
            r_d_rdata <= '0;
            r_cnt     <= 3'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_win_d  <= w_pick_d;
                        r_last_d <= w_pick_d;
                        if (w_pick_d) begin
                            r_we      <= d_we;
                            r_err     <= w_d_err;
                            r_is_byte <= d_isByte;
                            r_is_half <= d_isHalf;
                            r_off     <= d_addr[1:0];
                            r_waddr   <= d_addr[ADDR_W-1:2];
                            r_be      <= w_d_be;
                            r_wdata   <= w_d_wdata;
                        end else begin
                            r_we      <= 1'b0;
                            r_err     <= 1'b0;
                            r_is_byte <= 1'b0;
                            r_is_half <= 1'b0;
                            r_off     <= i_addr[1:0];
                            r_waddr   <= i_addr[ADDR_W-1:2];
                            r_be      <= 4'hF;
                            r_wdata   <= '0;
                        end
                    end
                end
                S_ISSUE: begin
                    r_cnt <= 3'(MEM_LAT);
                    if (r_win_d & (r_err | r_we)) begin
                        r_d_rdata <= '0;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 3'd1;
                    if (w_cnt_last) begin
                        if (r_win_d) begin
                            r_d_rdata <= w_extract;
                        end else begin
                            r_i_rdata <= mem_rdata;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign i_rdata = r_i_rdata;
    assign d_rdata = r_d_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (MEM_LAT 1 and 4) against a behavioural memory,
// with expected values from a reference model of lane, latency and arbitration rules.
module tb_mem_arbiter;

    localparam int LAT0 = 1;
    localparam int LAT1 = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       reset, i_req, i_gnt, i_rvalid;
    logic [1:0]       d_req, d_we, d_isByte, d_isHalf, d_isWord;
    logic [1:0]       d_gnt, d_rvalid, d_err, mem_en, mem_we;
    logic [1:0][31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata, mem_addr, mem_wdata;
    logic [1:0][3:0]  mem_be;

    bit [31:0] ref_mem [2][64];
    bit        m_last_d [2];
    int        n_assert = 0;
    int        n_fail   = 0;

    function automatic logic [31:0] init_word(input int w);
        if (w == 4)  return 32'h00500093;
        if (w == 16) return 32'hBEEF1234;
        return 32'hA5000000 ^ (32'(w) * 32'h01030507);
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dut
            localparam int LAT = (gi == 0) ? LAT0 : LAT1;
            logic [31:0] rdata_l;
            bit [31:0]   mem [64];
            bit [31:0]   pipe_d [4];
            bit          pipe_v [4];
            bit          loaded;

            mem_arbiter #(.WIDTH(32), .ADDR_W(32), .MEM_LAT(LAT)) u_dut (
                .clk(clk), .reset(reset[gi]),
                .i_req(i_req[gi]), .i_addr(i_addr[gi]), .i_gnt(i_gnt[gi]),
                .i_rvalid(i_rvalid[gi]), .i_rdata(i_rdata[gi]),
                .d_req(d_req[gi]), .d_we(d_we[gi]), .d_addr(d_addr[gi]), .d_wdata(d_wdata[gi]),
                .d_isByte(d_isByte[gi]), .d_isHalf(d_isHalf[gi]), .d_isWord(d_isWord[gi]),
                .d_gnt(d_gnt[gi]), .d_rvalid(d_rvalid[gi]), .d_rdata(d_rdata[gi]), .d_err(d_err[gi]),
                .mem_en(mem_en[gi]), .mem_we(mem_we[gi]), .mem_addr(mem_addr[gi]),
                .mem_wdata(mem_wdata[gi]), .mem_be(mem_be[gi]), .mem_rdata(rdata_l)
            );

            // Memory device: read data appears LAT cycles after the strobe, garbage otherwise.
            always @(negedge clk) begin
                if (!loaded) begin
                    for (int w = 0; w < 64; w++) mem[w] <= init_word(w);
                    loaded  <= 1'b1;
                    rdata_l <= 32'hDEADBEEF;
                end else begin
                    pipe_v[0] <= mem_en[gi] & ~mem_we[gi];
                    pipe_d[0] <= mem[mem_addr[gi][7:2]];
                    for (int j = 1; j < 4; j++) begin
                        pipe_v[j] <= pipe_v[j-1];
                        pipe_d[j] <= pipe_d[j-1];
                    end
                    if (mem_en[gi] & mem_we[gi]) begin
                        for (int b = 0; b < 4; b++) begin
                            if (mem_be[gi][b]) mem[mem_addr[gi][7:2]][8*b +: 8] <= mem_wdata[gi][8*b +: 8];
                        end
                    end
                    rdata_l <= pipe_v[LAT-1] ? pipe_d[LAT-1] : $urandom;
                end
            end
        end
    endgenerate

    function automatic logic [159:0] outs(input int k);
        return {21'b0, i_gnt[k], i_rvalid[k], i_rdata[k], d_gnt[k], d_rvalid[k], d_rdata[k],
                d_err[k], mem_en[k], mem_we[k], mem_addr[k], mem_wdata[k], mem_be[k]};
    endfunction

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One uncontended transaction; sz = {byte, half, word}.
    task automatic xact(input int k, input bit is_d, input bit we, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [2:0] sz);
        int lat, t_done, n_en, w;
        bit bad, got_g, got_v, stray, is_st;
        logic [1:0]  off;
        logic [3:0]  e_be;
        logic [31:0] e_wd, e_rd, word;
        lat   = (k == 0) ? LAT0 : LAT1;
        off   = addr[1:0];
        w     = int'(addr[7:2]);
        is_st = is_d && we;
        bad   = is_d && (!(sz == 3'b100 || sz == 3'b010 || sz == 3'b001) ||
                         (sz[1] && off[0]) || (sz[0] && off != 2'b00));
        word  = ref_mem[k][w];
        if (!is_d || sz[0]) begin
            e_be = 4'hF; e_wd = wd; e_rd = word;
        end else if (sz[1]) begin
            e_be = off[1] ? 4'hC : 4'h3; e_wd = {2{wd[15:0]}}; e_rd = (word >> (16 * off[1])) & 32'hFFFF;
        end else begin
            e_be = 4'b0001 << off; e_wd = {4{wd[7:0]}}; e_rd = (word >> (8 * off)) & 32'hFF;
        end
        if (bad || is_st) e_rd = 32'h0;
        t_done = (bad || is_st) ? 2 : 2 + lat;
        if (is_st && !bad) begin
            for (int b = 0; b < 4; b++) if (e_be[b]) ref_mem[k][w][8*b +: 8] = e_wd[8*b +: 8];
        end
        if (is_d) begin
            d_req[k] = 1'b1; d_we[k] = we; d_addr[k] = addr; d_wdata[k] = wd;
            {d_isByte[k], d_isHalf[k], d_isWord[k]} = sz;
        end else begin
            i_req[k] = 1'b1; i_addr[k] = addr;
        end
        n_en = 0; got_g = 0; got_v = 0; stray = 0;
        for (int n = 1; n <= 20 && !got_v; n++) begin
            @(negedge clk);
            stray |= is_d ? (i_gnt[k] | i_rvalid[k]) : (d_gnt[k] | d_rvalid[k]);
            if (mem_en[k]) begin
                n_en++;
                chk($sformatf("%0d:mem_addr@%0h", k, addr), mem_addr[k], addr & 32'hFFFFFFFC);
                chk($sformatf("%0d:mem_be@%0h", k, addr), mem_be[k], e_be);
                chk($sformatf("%0d:mem_we@%0h", k, addr), mem_we[k], is_st);
                if (is_st) chk($sformatf("%0d:mem_wdata@%0h", k, addr), mem_wdata[k], e_wd);
            end
            if (is_d ? d_gnt[k] : i_gnt[k]) begin
                chk($sformatf("%0d:gnt_time@%0h", k, addr), n, 1);
                got_g = 1;
                if (is_d) d_req[k] = 1'b0; else i_req[k] = 1'b0;
            end
            if (is_d ? d_rvalid[k] : i_rvalid[k]) begin
                got_v = 1;
                chk($sformatf("%0d:rvalid_time@%0h", k, addr), n, t_done);
                chk($sformatf("%0d:rdata@%0h", k, addr), is_d ? d_rdata[k] : i_rdata[k], e_rd);
                if (is_d) chk($sformatf("%0d:d_err@%0h", k, addr), d_err[k], bad);
            end
        end
        chk($sformatf("%0d:completed@%0h", k, addr), {got_g, got_v}, 2'b11);
        chk($sformatf("%0d:mem_en_count@%0h", k, addr), n_en, bad ? 0 : 1);
        chk($sformatf("%0d:stray@%0h", k, addr), stray, 1'b0);
        d_req[k] = 1'b0; i_req[k] = 1'b0;
        m_last_d[k] = is_d;
        @(negedge clk);
    endtask

    // Fetch and word load raised together; the model picks the winner from last grant.
    task automatic tie(input int k, input logic [31:0] ia, input logic [31:0] da);
        int lat, ig, dg, iv, dv, n_en, e_ig, e_dg, e_iv, e_dv;
        bit first_d;
        lat     = (k == 0) ? LAT0 : LAT1;
        first_d = !m_last_d[k];
        e_ig = first_d ? 4 + lat : 1;       e_dg = first_d ? 1 : 4 + lat;
        e_iv = first_d ? 5 + 2*lat : 2 + lat; e_dv = first_d ? 2 + lat : 5 + 2*lat;
        i_req[k] = 1'b1; i_addr[k] = ia;
        d_req[k] = 1'b1; d_we[k] = 1'b0; d_addr[k] = da;
        {d_isByte[k], d_isHalf[k], d_isWord[k]} = 3'b001;
        ig = -1; dg = -1; iv = -1; dv = -1; n_en = 0;
        for (int n = 1; n <= 30 && (iv < 0 || dv < 0); n++) begin
            @(negedge clk);
            if (mem_en[k]) n_en++;
            if (i_gnt[k] && ig < 0) begin ig = n; i_req[k] = 1'b0; end
            if (d_gnt[k] && dg < 0) begin dg = n; d_req[k] = 1'b0; end
            if (i_rvalid[k] && iv < 0) begin
                iv = n;
                chk($sformatf("%0d:tie_i_rdata", k), i_rdata[k], ref_mem[k][ia[7:2]]);
            end
            if (d_rvalid[k] && dv < 0) begin
                dv = n;
                chk($sformatf("%0d:tie_d_rdata", k), d_rdata[k], ref_mem[k][da[7:2]]);
            end
        end
        chk($sformatf("%0d:tie_i_gnt_time", k), ig, e_ig);
        chk($sformatf("%0d:tie_d_gnt_time", k), dg, e_dg);
        chk($sformatf("%0d:tie_i_rvalid_time", k), iv, e_iv);
        chk($sformatf("%0d:tie_d_rvalid_time", k), dv, e_dv);
        chk($sformatf("%0d:tie_mem_en_count", k), n_en, 2);
        i_req[k] = 1'b0; d_req[k] = 1'b0;
        m_last_d[k] = !first_d;
        @(negedge clk);
    endtask

    task automatic rand_xacts(input int k, input int count);
        bit          isd, we;
        logic [31:0] a, wd;
        logic [2:0]  sz;
        for (int t = 0; t < count; t++) begin
            if (t % 6 == 5) begin
                tie(k, {24'd0, 6'($urandom_range(0, 63)), 2'b00}, {24'd0, 6'($urandom_range(0, 63)), 2'b00});
            end else begin
                isd = ($urandom_range(0, 2) != 0);
                we  = isd && ($urandom_range(0, 1) == 1);
                a   = 32'($urandom_range(0, 255));
                wd  = $urandom;
                case ($urandom_range(0, 6))
                    0, 1:    sz = 3'b100;
                    2, 3:    sz = 3'b010;
                    4, 5:    sz = 3'b001;
                    default: sz = 3'($urandom_range(0, 7));
                endcase
                xact(k, isd, we, a, wd, sz);
            end
        end
    endtask

    initial begin
        int activity;
        reset = 2'b11; i_req = '0; d_req = '0; d_we = '0;
        d_isByte = '0; d_isHalf = '0; d_isWord = '0;
        i_addr = '0; d_addr = '0; d_wdata = '0;
        for (int k = 0; k < 2; k++) begin
            m_last_d[k] = 1'b0;
            for (int w = 0; w < 64; w++) ref_mem[k][w] = init_word(w);
        end
        repeat (3) @(negedge clk);
        chk("0:reset_outputs", outs(0), '0);
        chk("1:reset_outputs", outs(1), '0);
        reset = 2'b00;

        // MEM_LAT = 1: directed steps, then random traffic.
        tie(0, 32'h10, 32'h40);
        tie(0, 32'h14, 32'h44);
        xact(0, 1'b0, 1'b0, 32'h10, 32'h0, 3'b001);
        xact(0, 1'b1, 1'b1, 32'h23, 32'h000000AB, 3'b100);
        xact(0, 1'b1, 1'b0, 32'h42, 32'h0, 3'b010);
        xact(0, 1'b1, 1'b0, 32'h41, 32'h0, 3'b100);
        xact(0, 1'b1, 1'b0, 32'h20, 32'h0, 3'b001);
        tie(0, 32'h10, 32'h20);
        xact(0, 1'b1, 1'b0, 32'h06, 32'h0, 3'b001);
        xact(0, 1'b1, 1'b0, 32'h08, 32'h0, 3'b101);
        xact(0, 1'b1, 1'b1, 32'h32, 32'h12345678, 3'b010);
        xact(0, 1'b1, 1'b0, 32'h30, 32'h0, 3'b001);
        rand_xacts(0, 30);

        // MEM_LAT = 4.
        xact(1, 1'b0, 1'b0, 32'h10, 32'h0, 3'b001);
        xact(1, 1'b1, 1'b1, 32'h21, 32'h0000C3C3, 3'b100);
        xact(1, 1'b1, 1'b0, 32'h20, 32'h0, 3'b001);
        rand_xacts(1, 20);

        // Reset while a MEM_LAT = 4 fetch sits in WAIT.
        i_req[1] = 1'b1; i_addr[1] = 32'h10;
        @(negedge clk);
        chk("1:abort_i_gnt", i_gnt[1], 1'b1);
        i_req[1] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset[1] = 1'b1;
        @(negedge clk);
        chk("1:abort_outputs", outs(1), '0);
        reset[1] = 1'b0;
        m_last_d[1] = 1'b0;
        activity = 0;
        repeat (8) begin
            @(negedge clk);
            if (i_rvalid[1] | d_rvalid[1] | i_gnt[1] | d_gnt[1] | mem_en[1]) activity++;
        end
        chk("1:abort_no_activity", activity, 0);
        tie(1, 32'h10, 32'h40);
        xact(1, 1'b1, 1'b0, 32'h42, 32'h0, 3'b010);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
